// File: rtl/dma_unpack_pkg.sv
// Shared types and constants for the DMA frame unpacker.
package dma_unpack_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} unpack_st_e;

  localparam logic [3:0] KEEP_LANE    = 4'hF;
  localparam int         PIX_PER_BEAT = 2;

  // A nibble that is neither fully on nor fully off is an illegal byte mask.
  function automatic logic nib_bad(input logic [3:0] n);
    return (n != 4'h0) && (n != KEEP_LANE);
  endfunction

endpackage

// File: rtl/dma_unpack_pos_cnt.sv
// Pixel x/y position counters with start-of-frame, end-of-line and end-of-frame decodes.
module dma_unpack_pos_cnt #(
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_adv,
  output logic o_sof,
  output logic o_eol,
  output logic o_eof
);

  localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (o_eol) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_sof = (r_x == '0) && (r_y == '0);
  assign o_eol = (r_x == X_LAST);
  assign o_eof = o_eol && (r_y == Y_LAST);

endmodule

// File: rtl/dma_frame_unpacker.sv
// Unpacks 64-bit DMA read beats into a 32-bit pixel stream with SOF/EOL markers.
// Optional keep-error counter port o_err_cnt is built when UNPACK_ERR_CNT_EN is defined.
module dma_frame_unpacker
  import dma_unpack_pkg::*;
#(
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int PIXEL_WIDTH  = 32
) (
  input  logic                                io_peripheralClk,
  input  logic                                io_peripheralReset,
  input  logic                                i_enable,
  input  logic [PIX_PER_BEAT*PIXEL_WIDTH-1:0] dma_rdata,
  input  logic                                dma_rvalid,
  input  logic [7:0]                          dma_rkeep,
  output logic                                dma_rready,
  output logic [PIXEL_WIDTH-1:0]              pix_tdata,
  output logic                                pix_tvalid,
  input  logic                                pix_tready,
  output logic                                pix_tuser,
  output logic                                pix_tlast,
  output logic                                o_frame_done,
  output logic                                o_keep_err
`ifdef UNPACK_ERR_CNT_EN
  ,
  output logic [15:0]                         o_err_cnt
`endif
);

  localparam int PW = PIXEL_WIDTH;

  unpack_st_e r_state, w_next;
  logic [PIX_PER_BEAT*PW-1:0] r_hold;
  logic [PIX_PER_BEAT-1:0]    r_lv;
  logic r_keep_err;
  logic w_hs, w_eof_hs, w_acc, w_lo_ok, w_hi_ok, w_err;
  logic w_sof, w_eol, w_eof;

  dma_unpack_pos_cnt #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_pos (
    .i_clk(io_peripheralClk),
    .i_rst(io_peripheralReset),
    .i_adv(w_hs),
    .o_sof(w_sof),
    .o_eol(w_eol),
    .o_eof(w_eof)
  );

  // The presented pixel always sits in the low slot; the high lane shifts down once the low one goes.
  assign w_hs     = r_lv[0] && pix_tready;
  assign w_eof_hs = w_hs && w_eof;
  // No beat is taken on a frame's final handshake: the hold is flushed there and must not swallow the next frame.
  assign dma_rready = (r_state == ACTIVE) && !w_eof_hs &&
                      ((r_lv == 2'b00) || ((r_lv == 2'b01) && w_hs));
  assign w_acc   = dma_rready && dma_rvalid;
  assign w_lo_ok = (dma_rkeep[3:0] == KEEP_LANE);
  assign w_hi_ok = (dma_rkeep[7:4] == KEEP_LANE);
  assign w_err   = nib_bad(dma_rkeep[3:0]) || nib_bad(dma_rkeep[7:4]) || (dma_rkeep == 8'h00);

  always_ff @(posedge io_peripheralClk) begin
    if (io_peripheralReset) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_lv       <= '0;
      r_keep_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_eof_hs) begin
        r_lv <= '0;
      end else if (w_acc) begin
        r_hold <= (w_hi_ok && !w_lo_ok) ? {dma_rdata[2*PW-1:PW], dma_rdata[2*PW-1:PW]} : dma_rdata;
        r_lv   <= {w_lo_ok && w_hi_ok, w_lo_ok || w_hi_ok};
      end else if (w_hs) begin
        r_hold[PW-1:0] <= r_hold[2*PW-1:PW];
        r_lv           <= {1'b0, r_lv[1]};
      end
      if (w_acc && w_err) r_keep_err <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_enable) w_next = ACTIVE;
      ACTIVE:  if (w_eof_hs) w_next = FINISH;
      FINISH:  w_next = i_enable ? ACTIVE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign pix_tdata    = r_hold[PW-1:0];
  assign pix_tvalid   = r_lv[0];
  assign pix_tuser    = r_lv[0] && w_sof;
  assign pix_tlast    = r_lv[0] && w_eol;
  assign o_frame_done = (r_state == FINISH);
  assign o_keep_err   = r_keep_err;

`ifdef UNPACK_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge io_peripheralClk) begin
    if (io_peripheralReset)                              r_err_cnt <= '0;
    else if (w_acc && w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign o_err_cnt = r_err_cnt;
`endif

endmodule
